// File: rtl/burst_rd_dma.sv
// burst_rd_dma
//   Avalon-MM burst read master. It copies one packet out of a circular
//   capture buffer in host memory into the downstream packet FIFO. Bursts
//   are split at the ring end and at MAX_BURST. Only one burst is in flight
//   at a time. The final beat of the packet is tagged with fifo_last.
//
// Ports
//   clk, reset            clock; synchronous active-low reset
//   start                 one-cycle request, honoured only when idle
//   ring_base, ring_end   ring window [base, end), BYTES-aligned
//   pkt_begin, pkt_end    packet [begin, end); end < begin means it wraps
//   busy, done, err       status: transfer active / completion / bad request
//   fifo_data, fifo_wr    registered copy of the read data and its valid strobe
//   fifo_last             final beat marker, coincident with fifo_wr
//   fifo_almost_full      holds off new bursts (never an accepted one)
//   avm_*                 Avalon-MM burst read master port
module burst_rd_dma #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int BC_W      = $clog2(MAX_BURST) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] ring_base,
  input  logic [ADDR_W-1:0] ring_end,
  input  logic [ADDR_W-1:0] pkt_begin,
  input  logic [ADDR_W-1:0] pkt_end,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_wr,
  output logic              fifo_last,
  input  logic              fifo_almost_full,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [BC_W-1:0]   avm_burstcount,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  localparam int BYTES = DATA_W / 8;
  localparam int SH    = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, DATA, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ring_base_q, ring_base_d;
  logic [ADDR_W-1:0] ring_end_q, ring_end_d;
  logic [ADDR_W-1:0] pkt_begin_q, pkt_begin_d;
  logic [ADDR_W-1:0] pkt_end_q, pkt_end_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic [BC_W-1:0]   beats_q, beats_d;
  logic [ADDR_W-1:0] avm_address_q, avm_address_d;
  logic [BC_W-1:0]   avm_burstcount_q, avm_burstcount_d;
  logic              avm_read_q, avm_read_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] fifo_data_q, fifo_data_d;
  logic              fifo_wr_q, fifo_wr_d;
  logic              fifo_last_q, fifo_last_d;

  logic              valid_c;
  logic [ADDR_W-1:0] len_c;
  logic [ADDR_W:0]   len_round_c;
  logic [ADDR_W-1:0] words_c;
  logic [ADDR_W-1:0] start_addr_c;
  logic [ADDR_W-1:0] next_addr_c;

  // Burst length: limited by MAX_BURST, the words still owed, and the room
  // left before ring_end so that no burst ever straddles the wrap point.
  function automatic logic [BC_W-1:0] calc_burst(input logic [ADDR_W-1:0] addr,
                                                 input logic [ADDR_W-1:0] words,
                                                 input logic [ADDR_W-1:0] rend);
    logic [ADDR_W-1:0] room;
    logic [ADDR_W-1:0] n;
    room = (rend - addr) >> SH;
    n    = ADDR_W'(MAX_BURST);
    if (words < n) n = words;
    if (room < n) n = room;
    return n[BC_W-1:0];
  endfunction

  // Request decode from the captured pointers. A packet that begins exactly
  // at ring_end really starts at ring_base, so the start address is folded.
  always_comb begin
    valid_c = (pkt_begin_q[SH-1:0] == '0) &&
              (pkt_begin_q >= ring_base_q) && (pkt_begin_q <= ring_end_q) &&
              (pkt_end_q >= ring_base_q) && (pkt_end_q <= ring_end_q);
    if (pkt_end_q >= pkt_begin_q) begin
      len_c = pkt_end_q - pkt_begin_q;
    end else begin
      len_c = (ring_end_q - pkt_begin_q) + (pkt_end_q - ring_base_q);
    end
    len_round_c  = {1'b0, len_c} + (ADDR_W+1)'(BYTES - 1);
    words_c      = ADDR_W'(len_round_c >> SH);
    start_addr_c = (pkt_begin_q == ring_end_q) ? ring_base_q : pkt_begin_q;
    next_addr_c  = addr_q + (ADDR_W'(avm_burstcount_q) << SH);
    if (next_addr_c == ring_end_q) next_addr_c = ring_base_q;
  end

  // Next-state and output logic. The CALC step can raise avm_read directly
  // so the first request appears two cycles after start.
  always_comb begin
    state_d          = state_q;
    ring_base_d      = ring_base_q;
    ring_end_d       = ring_end_q;
    pkt_begin_d      = pkt_begin_q;
    pkt_end_d        = pkt_end_q;
    addr_d           = addr_q;
    words_d          = words_q;
    beats_d          = beats_q;
    avm_address_d    = avm_address_q;
    avm_burstcount_d = avm_burstcount_q;
    avm_read_d       = avm_read_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    err_d            = 1'b0;
    fifo_data_d      = avm_readdata;
    fifo_wr_d        = 1'b0;
    fifo_last_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ring_base_d = ring_base;
          ring_end_d  = ring_end;
          pkt_begin_d = pkt_begin;
          pkt_end_d   = pkt_end;
          busy_d      = 1'b1;
          state_d     = CALC;
        end
      end
      CALC: begin
        if (!valid_c) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (len_c == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          addr_d  = start_addr_c;
          words_d = words_c;
          state_d = ISSUE;
          if (!fifo_almost_full) begin
            avm_read_d       = 1'b1;
            avm_address_d    = start_addr_c;
            avm_burstcount_d = calc_burst(start_addr_c, words_c, ring_end_q);
          end
        end
      end
      ISSUE: begin
        // A posted request is held untouched until the slave takes it,
        // even if the FIFO fills up meanwhile.
        if (avm_read_q) begin
          if (!avm_waitrequest) begin
            avm_read_d = 1'b0;
            beats_d    = avm_burstcount_q;
            words_d    = words_q - ADDR_W'(avm_burstcount_q);
            addr_d     = next_addr_c;
            state_d    = DATA;
          end
        end else if (!fifo_almost_full) begin
          avm_read_d       = 1'b1;
          avm_address_d    = addr_q;
          avm_burstcount_d = calc_burst(addr_q, words_q, ring_end_q);
        end
      end
      DATA: begin
        if (avm_readdatavalid) begin
          fifo_wr_d = 1'b1;
          beats_d   = beats_q - BC_W'(1);
          if (beats_q == BC_W'(1)) begin
            if (words_q == '0) begin
              fifo_last_d = 1'b1;
              state_d     = DONE;
            end else begin
              state_d = ISSUE;
            end
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= IDLE;
      ring_base_q      <= '0;
      ring_end_q       <= '0;
      pkt_begin_q      <= '0;
      pkt_end_q        <= '0;
      addr_q           <= '0;
      words_q          <= '0;
      beats_q          <= '0;
      avm_address_q    <= '0;
      avm_burstcount_q <= '0;
      avm_read_q       <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      fifo_data_q      <= '0;
      fifo_wr_q        <= 1'b0;
      fifo_last_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      ring_base_q      <= ring_base_d;
      ring_end_q       <= ring_end_d;
      pkt_begin_q      <= pkt_begin_d;
      pkt_end_q        <= pkt_end_d;
      addr_q           <= addr_d;
      words_q          <= words_d;
      beats_q          <= beats_d;
      avm_address_q    <= avm_address_d;
      avm_burstcount_q <= avm_burstcount_d;
      avm_read_q       <= avm_read_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      err_q            <= err_d;
      fifo_data_q      <= fifo_data_d;
      fifo_wr_q        <= fifo_wr_d;
      fifo_last_q      <= fifo_last_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign fifo_data      = fifo_data_q;
  assign fifo_wr        = fifo_wr_q;
  assign fifo_last      = fifo_last_q;
  assign avm_address    = avm_address_q;
  assign avm_read       = avm_read_q;
  assign avm_burstcount = avm_burstcount_q;

endmodule

// File: tb/tb_burst_rd_dma.sv
// tb_burst_rd_dma
//   Directed bench for burst_rd_dma with a behavioural Avalon burst slave
//   and a FIFO monitor. Expected bursts and beats are queued when a packet
//   is launched and consumed as the DUT produces them.
module tb_burst_rd_dma;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 16;
  localparam int BC_W      = $clog2(MAX_BURST) + 1;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] ring_base;
  logic [ADDR_W-1:0] ring_end;
  logic [ADDR_W-1:0] pkt_begin;
  logic [ADDR_W-1:0] pkt_end;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_wr;
  logic              fifo_last;
  logic              fifo_almost_full;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [BC_W-1:0]   avm_burstcount;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic              avm_waitrequest;

  burst_rd_dma #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .BC_W(BC_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .ring_base(ring_base), .ring_end(ring_end),
    .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .busy(busy), .done(done), .err(err),
    .fifo_data(fifo_data), .fifo_wr(fifo_wr), .fifo_last(fifo_last),
    .fifo_almost_full(fifo_almost_full),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_burstcount(avm_burstcount), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
  );

  int checks_total;
  int checks_passed;
  int cyc;
  int last_cycle;

  logic [ADDR_W-1:0] exp_addr_q[$];
  int                exp_bc_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  logic              exp_last_q[$];

  bit                rand_wait;
  bit                gaps;
  int                hold_after;
  int                delivered;
  int                pend;
  int                accept_count;
  logic [ADDR_W-1:0] beat_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Host memory contents: every word is a fixed scramble of its address.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] addr);
    return addr ^ {addr[15:0], addr[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_burst(input logic [ADDR_W-1:0] addr, input int bc,
                            input bit final_burst);
    exp_addr_q.push_back(addr);
    exp_bc_q.push_back(bc);
    for (int i = 0; i < bc; i++) begin
      exp_data_q.push_back(mem_word(addr + ADDR_W'(4 * i)));
      exp_last_q.push_back(final_burst && (i == bc - 1));
    end
  endtask

  task automatic apply_stimulus(input logic [ADDR_W-1:0] rb, input logic [ADDR_W-1:0] re,
                                input logic [ADDR_W-1:0] pb, input logic [ADDR_W-1:0] pe);
    @(negedge clk);
    ring_base = rb;
    ring_end  = re;
    pkt_begin = pb;
    pkt_end   = pe;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_err"}, err, 0);
    check_output({tag, "_fifo_wr"}, fifo_wr, 0);
    check_output({tag, "_fifo_last"}, fifo_last, 0);
    check_output({tag, "_fifo_data"}, fifo_data, 0);
    check_output({tag, "_avm_read"}, avm_read, 0);
    check_output({tag, "_avm_address"}, avm_address, 0);
    check_output({tag, "_avm_burstcount"}, avm_burstcount, 0);
  endtask

  // Waits for done within a cycle budget; optionally fires a start pulse
  // with unrelated pointers while the transfer is still running.
  task automatic wait_done(input string tag, input int budget, input int inject_at);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      if (n == inject_at) begin
        start     = 1'b1;
        pkt_begin = 32'h0000_1800;
        pkt_end   = 32'h0000_1900;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check_output({tag, "_done_seen"}, done, 1);
    if (done === 1'b1) begin
      check_output({tag, "_done_after_last"}, cyc - last_cycle, 1);
      check_output({tag, "_busy_drop"}, busy, 0);
    end
    @(negedge clk);
    check_output({tag, "_done_one_cycle"}, done, 0);
    check_output({tag, "_beats_left"}, exp_data_q.size(), 0);
    check_output({tag, "_bursts_left"}, exp_addr_q.size(), 0);
  endtask

  // Avalon burst slave: optional random waitrequest, optional gaps in the
  // returned beats, and a beat cap used to strand beats across a reset.
  initial begin
    bit                prev_wait;
    bit                prev_acc;
    logic [ADDR_W-1:0] prev_addr;
    logic [BC_W-1:0]   prev_bc;
    prev_wait         = 1'b0;
    prev_acc          = 1'b0;
    prev_addr         = '0;
    prev_bc           = '0;
    avm_readdata      = 32'hDEAD_BEEF;
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (prev_wait) begin
          check_output("hold_read", avm_read, 1);
          check_output("hold_address", avm_address, prev_addr);
          check_output("hold_burstcount", avm_burstcount, prev_bc);
        end
        if (prev_acc) check_output("read_drop", avm_read, 0);
      end
      prev_wait = 1'b0;
      prev_acc  = 1'b0;
      avm_readdatavalid = 1'b0;
      if (pend > 0 && delivered < hold_after && (!gaps || $urandom_range(0, 3) != 0)) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = mem_word(beat_addr);
        beat_addr         = beat_addr + 32'd4;
        pend--;
        delivered++;
      end
      avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      if (reset === 1'b1 && avm_read === 1'b1) begin
        if (avm_waitrequest) begin
          prev_wait = 1'b1;
          prev_addr = avm_address;
          prev_bc   = avm_burstcount;
        end else begin
          prev_acc = 1'b1;
          accept_count++;
          check_output("one_outstanding", pend, 0);
          check_output("burst_expected", exp_addr_q.size() > 0, 1);
          if (exp_addr_q.size() > 0) begin
            check_output("burst_address", avm_address, exp_addr_q.pop_front());
            check_output("burst_count", avm_burstcount, exp_bc_q.pop_front());
          end
          pend      = int'(avm_burstcount);
          beat_addr = avm_address;
        end
      end
    end
  end

  // FIFO side monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (fifo_wr === 1'b1) begin
        check_output("beat_expected", exp_data_q.size() > 0, 1);
        if (exp_data_q.size() > 0) begin
          check_output("beat_data", fifo_data, exp_data_q.pop_front());
          check_output("beat_last", fifo_last, exp_last_q.pop_front());
        end
        if (fifo_last === 1'b1) last_cycle = cyc;
      end
    end
  end

  initial begin
    int reads;
    int acc0;
    int any_wr;
    int n;
    checks_total     = 0;
    checks_passed    = 0;
    last_cycle       = -100;
    rand_wait        = 1'b0;
    gaps             = 1'b0;
    hold_after       = 1000000;
    delivered        = 0;
    pend             = 0;
    accept_count     = 0;
    beat_addr        = '0;
    reset            = 1'b0;
    start            = 1'b0;
    ring_base        = '0;
    ring_end         = '0;
    pkt_begin        = '0;
    pkt_end          = '0;
    fifo_almost_full = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;

    // Single 10-beat burst with exact start-up timing.
    push_burst(32'h1000, 10, 1'b1);
    apply_stimulus(32'h1000, 32'h2000, 32'h1000, 32'h1028);
    check_output("t1_busy_T1", busy, 1);
    check_output("t1_read_T1", avm_read, 0);
    @(negedge clk);
    check_output("t1_read_T2", avm_read, 1);
    check_output("t1_addr_T2", avm_address, 32'h1000);
    check_output("t1_bc_T2", avm_burstcount, 10);
    wait_done("t1", 200, -1);

    // 200-byte packet split 16/16/16/2, with FIFO backpressure mid-packet.
    push_burst(32'h1000, 16, 1'b0);
    push_burst(32'h1040, 16, 1'b0);
    push_burst(32'h1080, 16, 1'b0);
    push_burst(32'h10C0, 2, 1'b1);
    apply_stimulus(32'h1000, 32'h2000, 32'h1000, 32'h10C8);
    repeat (25) @(negedge clk);
    fifo_almost_full = 1'b1;
    repeat (3) @(negedge clk);
    reads = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (avm_read === 1'b1) reads++;
    end
    check_output("t2_no_read_while_full", reads, 0);
    fifo_almost_full = 1'b0;
    wait_done("t2", 500, -1);

    // Wrapping packet: 4 beats up to ring end, then 8 from ring base.
    push_burst(32'h10F0, 4, 1'b0);
    push_burst(32'h1000, 8, 1'b1);
    apply_stimulus(32'h1000, 32'h1100, 32'h10F0, 32'h1020);
    wait_done("t3", 200, -1);

    // 41-byte packet rounds up to 11 beats.
    push_burst(32'h1000, 11, 1'b1);
    apply_stimulus(32'h1000, 32'h2000, 32'h1000, 32'h1029);
    wait_done("t4", 200, -1);

    // Empty packet: done two cycles after start, no reads.
    acc0 = accept_count;
    apply_stimulus(32'h1000, 32'h2000, 32'h1200, 32'h1200);
    check_output("t5_busy_T1", busy, 1);
    check_output("t5_done_T1", done, 0);
    @(negedge clk);
    check_output("t5_done_T2", done, 1);
    check_output("t5_busy_T2", busy, 0);
    check_output("t5_read_T2", avm_read, 0);
    @(negedge clk);
    check_output("t5_done_T3", done, 0);
    check_output("t5_no_accept", accept_count - acc0, 0);

    // Misaligned begin: err pulse, no Avalon traffic.
    apply_stimulus(32'h1000, 32'h2000, 32'h1002, 32'h1040);
    check_output("t6_busy_T1", busy, 1);
    check_output("t6_err_T1", err, 0);
    @(negedge clk);
    check_output("t6_err_T2", err, 1);
    check_output("t6_busy_T2", busy, 0);
    check_output("t6_read_T2", avm_read, 0);
    @(negedge clk);
    check_output("t6_err_T3", err, 0);
    check_output("t6_no_accept", accept_count - acc0, 0);

    // End pointer outside the ring.
    apply_stimulus(32'h1000, 32'h2000, 32'h1000, 32'h3000);
    @(negedge clk);
    check_output("t7_err_T2", err, 1);
    check_output("t7_done_T2", done, 0);
    @(negedge clk);
    check_output("t7_no_accept", accept_count - acc0, 0);

    // Random waitrequest and beat gaps on a wrapping packet; a stray start
    // pulse while busy must not disturb it.
    rand_wait = 1'b1;
    gaps      = 1'b1;
    push_burst(32'h10F0, 4, 1'b0);
    push_burst(32'h1000, 16, 1'b0);
    push_burst(32'h1040, 16, 1'b1);
    apply_stimulus(32'h1000, 32'h1100, 32'h10F0, 32'h1080);
    wait_done("t8", 2000, 10);
    rand_wait = 1'b0;
    gaps      = 1'b0;
    check_output("t8_no_extra_err", err, 0);

    // Reset in DATA with 5 beats still owed by the slave.
    delivered  = 0;
    hold_after = 11;
    exp_addr_q.push_back(32'h1000);
    exp_bc_q.push_back(16);
    for (int i = 0; i < 11; i++) begin
      exp_data_q.push_back(mem_word(32'h1000 + ADDR_W'(4 * i)));
      exp_last_q.push_back(1'b0);
    end
    apply_stimulus(32'h1000, 32'h2000, 32'h1000, 32'h1040);
    n = 0;
    while (delivered < 11 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("t9_beats_before_reset", delivered, 11);
    repeat (2) @(negedge clk);
    check_output("t9_busy_before_reset", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("t9");
    reset      = 1'b1;
    hold_after = 1000000;
    any_wr     = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_wr === 1'b1) any_wr++;
    end
    check_output("t9_late_beats_dropped", any_wr, 0);
    check_output("t9_slave_drained", pend, 0);
    check_output("t9_beats_left", exp_data_q.size(), 0);

    // Fresh transfer after the reset.
    push_burst(32'h1400, 8, 1'b1);
    apply_stimulus(32'h1000, 32'h2000, 32'h1400, 32'h1420);
    check_output("t10_busy_T1", busy, 1);
    wait_done("t10", 200, -1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/burst_rd_dma.md
# burst_rd_dma

Parametrised Avalon-MM burst read master that copies one packet from a circular capture buffer in host memory into the downstream packet FIFO. It is the successor of the single-region packet reader: configurable data/address width and maximum burst, ring-buffer wrap-around, FIFO backpressure, a last-beat marker and error reporting. It sits between the control register block, which supplies the packet pointers and the start pulse, and the packet FIFO.

## Interface
- ADDR_W, 32, Avalon byte-address width.
- DATA_W, 32, data width; BYTES = DATA_W/8, a power of two ≥ 4.
- MAX_BURST, 16, maximum burst length in beats, power of two ≤ 256.
- BC_W, $clog2(MAX_BURST)+1, burstcount width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- start  in  1  one-cycle request; ignored unless idle.
- ring_base  in  ADDR_W  ring start byte address, BYTES-aligned.
- ring_end  in  ADDR_W  ring end byte address (exclusive), BYTES-aligned, > ring_base.
- pkt_begin  in  ADDR_W  packet first byte address.
- pkt_end  in  ADDR_W  packet end byte address (exclusive); pkt_end < pkt_begin means the packet wraps.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse.
- fifo_data  out  DATA_W  beat to FIFO.
- fifo_wr  out  1  FIFO write strobe.
- fifo_last  out  1  marks the final beat of the packet, valid with fifo_wr.
- fifo_almost_full  in  1  FIFO backpressure.
- avm_address  out  ADDR_W  burst start byte address.
- avm_read  out  1  read request.
- avm_burstcount  out  BC_W  beats in the burst.
- avm_readdata  in  DATA_W  read data.
- avm_readdatavalid  in  1  read data valid.
- avm_waitrequest  in  1  slave stall.

## Operation
- States: IDLE, CALC, ISSUE, DATA, DONE.
- IDLE + start: register all pointer inputs, then go to CALC.
- CALC checks validity. The request is invalid if pkt_begin is not BYTES-aligned, or if pkt_begin or pkt_end lies outside [ring_base, ring_end]. An invalid request pulses err and returns to IDLE with no Avalon traffic.
- CALC computes the packet length in bytes:
  - len = pkt_end − pkt_begin when pkt_end ≥ pkt_begin;
  - otherwise len = (ring_end − pkt_begin) + (pkt_end − ring_base).
- Words = ceil(len/BYTES). A partial last word is read whole.
- len = 0: go straight to DONE with no reads.
- Otherwise set the current address to pkt_begin and go to ISSUE.
- ISSUE waits until fifo_almost_full = 0. It then drives avm_read = 1 with:
  - avm_address = current address;
  - avm_burstcount = min(MAX_BURST, words remaining, (ring_end − address)/BYTES).
- Bursts never cross ring_end. The next address after a burst that ends at ring_end is ring_base.
- The request is accepted on the cycle where avm_read = 1 and avm_waitrequest = 0; the FSM then moves to DATA.
- DATA counts avm_readdatavalid beats. When the burst is complete, go to ISSUE if words remain, else DONE.
- Only one burst is outstanding at a time.
- DONE pulses done for one cycle, then returns to IDLE.
- Every readdatavalid beat in DATA produces exactly one fifo_wr. Beats arriving outside DATA are dropped.
- Integration rule: fifo_almost_full must assert with at least MAX_BURST free entries. The block does not stop an accepted burst.

## Timing
- Reset values: state IDLE; busy, done, err, fifo_wr, fifo_last, avm_read = 0; avm_address, avm_burstcount, fifo_data = 0.
- start sampled high at edge T:
  - busy = 1 from T+1;
  - avm_read = 1 earliest at T+2 (CALC takes one cycle).
- avm_address, avm_burstcount and avm_read are registered and held stable while avm_waitrequest = 1. avm_read drops the cycle after acceptance.
- fifo_data and fifo_wr are registered copies of avm_readdata and avm_readdatavalid (1-cycle latency). fifo_last is coincident with the final fifo_wr.
- done pulses in the cycle after the final fifo_wr, and busy drops in that same cycle.
- err pulses at T+2. busy is high only during T+1.
- The next ISSUE after the final beat of a burst is at least 1 cycle later.
- start while busy is ignored and has no side effects.
- Reset mid-transfer: reset asserted at any edge returns the block to reset values on that edge. Late beats are not forwarded.
- All address arithmetic is modulo 2^ADDR_W; ring wrap is applied before any overflow can occur.

## Test plan
- DATA_W=32, MAX_BURST=16, begin 0x1000, end 0x1028 → one burst, burstcount 10 at 0x1000; 10 fifo_wr with last on the 10th; done 1 cycle later.
- begin 0x1000, end 0x10C8 (200 B) → bursts 16/16/16/2 at 0x1000/0x1040/0x1080/0x10C0; 50 beats, data order preserved.
- Ring 0x1000–0x1100, begin 0x10F0, end 0x1020 → burst 4 at 0x10F0, then burst 8 at 0x1000; 12 beats.
- 41-byte packet → 11 beats. begin = end → done at T+2 with no avm_read. Misaligned begin 0x1002 → err pulse, avm_read never asserted.
- fifo_almost_full high mid-packet → no new avm_read until it drops, then resume at the correct address. Random waitrequest → address and burstcount stable until accepted; start pulses while busy are ignored.
- Reset asserted in DATA with 5 beats pending → all outputs at reset values on the next cycle; the pending beats produce no fifo_wr; a fresh start then completes normally.
